// File: rtl/seg7_scan_driver.sv
// Multiplexed NDIG-digit hex 7-segment driver with PWM brightness.
// Optional blink support is compiled in when SEG7_SCAN_BLINK_EN is defined.
//
// Ports:
//   clk, clr (async, active-high)
//   ld_valid/ld_ready, ld_data[4*NDIG], ld_dp[NDIG] : double-buffered value load
//   blank_lz, bright[4]    : leading-zero blanking, brightness 0..15
//   blink_mask[NDIG]       : per-digit blink enable (SEG7_SCAN_BLINK_EN only)
//   a_to_g[7], an[NDIG], dp : active-low registered display outputs
//   frame_done             : one-cycle pulse as the index wraps to digit 0
module seg7_scan_driver #(
   parameter int NDIG       = 8,
   parameter int PRESCALE_W = 17,
   parameter int BLINK_W    = 5
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [4*NDIG-1:0] ld_data,
   input  logic [NDIG-1:0]   ld_dp,
   input  logic              blank_lz,
   input  logic [3:0]        bright,
`ifdef SEG7_SCAN_BLINK_EN
   input  logic [NDIG-1:0]   blink_mask,
`endif
   output logic [6:0]        a_to_g,
   output logic [NDIG-1:0]   an,
   output logic              dp,
   output logic              frame_done
);

   localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IW-1:0] LAST = IW'(NDIG - 1);
   localparam logic [PRESCALE_W-1:0] P_ONE = PRESCALE_W'(1);

   if (NDIG < 1 || NDIG > 16 || PRESCALE_W < 4 || BLINK_W < 1) begin : g_param_chk
      $error("seg7_scan_driver: illegal parameter value");
   end

   logic [PRESCALE_W-1:0] presc_q;
   logic [IW-1:0]         idx_q;
   logic [4*NDIG-1:0]     disp_q, pend_q;
   logic [NDIG-1:0]       disp_dp_q, pend_dp_q;
   logic                  pend_full_q;
   logic [6:0]            seg_q, seg_d;
   logic [NDIG-1:0]       an_q, an_d;
   logic                  dp_q, dp_d;
   logic                  fd_q;

   logic [3:0] phase;
   logic       wrap, fwrap, accept;
   logic [3:0] nib;
   logic       nib_dp, above, en, lit, blink_dark;

   assign phase    = presc_q[PRESCALE_W-1 -: 4];
   assign wrap     = &presc_q;
   assign fwrap    = wrap && (idx_q == LAST);
   assign ld_ready = !pend_full_q;
   assign accept   = ld_valid && ld_ready;

`ifdef SEG7_SCAN_BLINK_EN
   logic [BLINK_W-1:0] blink_q;
   logic               nib_blk;
   assign blink_dark = nib_blk && blink_q[BLINK_W-1];

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         blink_q <= '0;
      end else if (fwrap) begin
         blink_q <= blink_q + BLINK_W'(1);
      end
   end
`else
   assign blink_dark = 1'b0;
`endif

   // Select the current digit and check whether any higher digit is nonzero.
   always_comb begin
      nib    = 4'h0;
      nib_dp = 1'b0;
      above  = 1'b0;
`ifdef SEG7_SCAN_BLINK_EN
      nib_blk = 1'b0;
`endif
      for (int j = 0; j < NDIG; j++) begin
         if (j == int'(idx_q)) begin
            nib    = disp_q[4*j +: 4];
            nib_dp = disp_dp_q[j];
`ifdef SEG7_SCAN_BLINK_EN
            nib_blk = blink_mask[j];
`endif
         end
         if (j > int'(idx_q)) begin
            above = above | (|disp_q[4*j +: 4]);
         end
      end
      en  = (idx_q == '0) || !blank_lz || above;
      lit = en && (phase <= bright) && !blink_dark;
   end

   always_comb begin
      seg_d = 7'h7F;
      an_d  = '1;
      dp_d  = 1'b1;
      if (lit) begin
         an_d[idx_q] = 1'b0;
         dp_d        = !nib_dp;
         case (nib)
            4'h0: seg_d = 7'h01;
            4'h1: seg_d = 7'h4F;
            4'h2: seg_d = 7'h12;
            4'h3: seg_d = 7'h06;
            4'h4: seg_d = 7'h4C;
            4'h5: seg_d = 7'h24;
            4'h6: seg_d = 7'h20;
            4'h7: seg_d = 7'h0F;
            4'h8: seg_d = 7'h00;
            4'h9: seg_d = 7'h04;
            4'hA: seg_d = 7'h08;
            4'hB: seg_d = 7'h60;
            4'hC: seg_d = 7'h31;
            4'hD: seg_d = 7'h42;
            4'hE: seg_d = 7'h30;
            default: seg_d = 7'h38;
         endcase
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         presc_q     <= '0;
         idx_q       <= '0;
         disp_q      <= '0;
         disp_dp_q   <= '0;
         pend_q      <= '0;
         pend_dp_q   <= '0;
         pend_full_q <= 1'b0;
         seg_q       <= 7'h7F;
         an_q        <= '1;
         dp_q        <= 1'b1;
         fd_q        <= 1'b0;
      end else begin
         presc_q <= presc_q + P_ONE;
         if (wrap) begin
            idx_q <= (idx_q == LAST) ? '0 : idx_q + IW'(1);
         end
         fd_q <= fwrap;
         // Display register only changes at the frame boundary; a load in
         // that very cycle bypasses the empty buffer.
         if (fwrap) begin
            if (pend_full_q) begin
               disp_q      <= pend_q;
               disp_dp_q   <= pend_dp_q;
               pend_full_q <= 1'b0;
            end else if (accept) begin
               disp_q    <= ld_data;
               disp_dp_q <= ld_dp;
            end
         end else if (accept) begin
            pend_q      <= ld_data;
            pend_dp_q   <= ld_dp;
            pend_full_q <= 1'b1;
         end
         seg_q <= seg_d;
         an_q  <= an_d;
         dp_q  <= dp_d;
      end
   end

   assign a_to_g     = seg_q;
   assign an         = an_q;
   assign dp         = dp_q;
   assign frame_done = fd_q;

endmodule
